uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Parametrised UART transmit framer: accepts a parallel word over a valid/ready handshake and serialises it as a complete asynchronous frame (start bit, DATA_W data bits, optional parity, 1–2 stop bits), one bit per baud tick. It sits between the TX FIFO/host interface and the TX pin, and consumes an external one-cycle `tick_i` strobe from the baud generator. Unlike the plain 8-bit shifter it replaces, it has configurable width, bit order and stop-bit count, idles high, and reports completion.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `MSB_FIRST`, 0: 0 = LSB first (UART standard); 1 = MSB first.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.
- `Clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick_i`  in  1  baud strobe; high for one `Clk` cycle per bit period.
- `valid_i`  in  1  `data_i` holds a word to send.
- `data_i`  in  DATA_W  word to transmit.
- `ready_o`  out  1  framer is idle and can accept a word.
- `serial_o`  out  1  TX line; idles high.
- `busy_o`  out  1  a frame is armed or in progress.
- `done_o`  out  1  one-cycle pulse when the last stop bit ends.

## Operation
- States: IDLE, ARM, START, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE: `ready_o`=1, `serial_o`=1. When `valid_i && ready_o`, capture `data_i` into the shift register, clear the bit counter, and go to ARM. `tick_i` is ignored in IDLE.
- ARM: `serial_o`=1 and the framer waits for the next `tick_i`, which moves it to START. Every bit therefore lasts exactly one full tick period.
- START: `serial_o`=0; on `tick_i` go to DATA.
- DATA: `serial_o` = current bit (bit 0 first if `MSB_FIRST`=0, bit DATA_W-1 first otherwise). On each `tick_i` shift and increment the counter. On the tick with counter = DATA_W-1, go to PARITY, or to STOP if parity is not compiled in.
- PARITY: `serial_o` = XOR of all captured data bits, XOR `PARITY_ODD`; on `tick_i` go to STOP.
- STOP: `serial_o`=1 for STOP_BITS tick periods. On the final tick go to IDLE and pulse `done_o`.
- `busy_o` = (state != IDLE). `ready_o` = (state == IDLE).
- `valid_i` outside IDLE is ignored. `data_i` changes after acceptance have no effect.
- Counter width is $clog2(DATA_W+1). It is also reused for stop-bit counting.

## Timing
- Reset values (cycle after `rst` sampled high): state IDLE, `serial_o`=1, `busy_o`=0, `done_o`=0, `ready_o`=1, shift register and counter cleared.
- Reset mid-frame aborts the frame: the line returns high on the next cycle and no `done_o` is generated.
- All outputs are registered, or decoded only from registered state.
- Accept at edge N: `ready_o`=0 and `busy_o`=1 from cycle N+1.
- `serial_o` changes one cycle after the `tick_i` that causes a bit transition.
- Frame length, from the first `tick_i` after acceptance: 1 + DATA_W + P + STOP_BITS tick periods, where P = 1 with parity, else 0.
- `done_o` is high in the same cycle state returns to IDLE, and `ready_o`=1 in that cycle. Back-to-back frames are accepted that cycle, with no idle gap beyond the ARM wait.
- `tick_i` held high for several cycles is treated as one bit per cycle. This is a caller error and is not checked.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity bit present; `PARITY_ODD` selects the sense.
- Macro undefined: the PARITY state and parity logic are not compiled; DATA goes directly to STOP; `PARITY_ODD` is ignored.

## Structure
- Shared `uart_pkg` holds:
  - the `tx_state_e` enum (IDLE, ARM, START, DATA, PARITY, STOP);
  - constants `UART_IDLE_LVL`=1'b1 and `UART_START_LVL`=1'b0;
  - legal-range localparams for DATA_W and STOP_BITS.
- No sub-module: one FSM `always_ff`, plus a shift register and counter, in a single module.
- The elaboration-time check on DATA_W/STOP_BITS ranges lives in this module.

## Test plan
- Default params (DATA_W=8, LSB first, 1 stop, no parity); send 0x31, tick every 16 cycles -> `serial_o` per tick: 0, 1,0,0,0,1,1,0,0, 1; `done_o` one pulse; `ready_o` back high.
- `MSB_FIRST`=1, send 0x31 -> data bits 0,0,1,1,0,0,0,1.
- `UART_TX_PARITY_EN`, send 0xA5 -> parity bit 0 when `PARITY_ODD`=0, 1 when `PARITY_ODD`=1; frame is 11 ticks.
- DATA_W=5, STOP_BITS=2, send 0x1F -> 0, 1,1,1,1,1, 1,1; `done_o` after the 8th tick.
- `valid_i` held high with 0x55 then 0xAA -> two consecutive frames; the second is accepted in the `done_o` cycle; `data_i` changes mid-frame are ignored.
- Assert `rst` during data bit 3 -> `serial_o`=1, `busy_o`=0 the next cycle, no `done_o`; a new frame sends correctly afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, line levels and legal parameter ranges.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    localparam int unsigned DATA_W_MIN    = 5;
    localparam int unsigned DATA_W_MAX    = 9;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits, optional parity, 1-2 stop bits, one bit per tick_i.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              serial_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    // Elaboration-time parameter range checks
    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_tx_framer: DATA_W out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS out of range");
    end
    if (MSB_FIRST > 1 || PARITY_ODD > 1) begin : g_bad_flags
        $error("uart_tx_framer: MSB_FIRST and PARITY_ODD must be 0 or 1");
    end

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              serial_d;
    logic              done_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Advance the shift register so the next bit to send sits at the output end
    function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
        if (MSB_FIRST != 0) begin
            return {v[DATA_W-2:0], 1'b0};
        end
        return {1'b0, v[DATA_W-1:1]};
    endfunction

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        serial_d = UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shreg_d = data_i;
                    cnt_d   = '0;
                    state_d = ARM;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data_i) ^ 1'(PARITY_ODD);
`endif
                end
            end
            ARM: begin
                if (tick_i) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick_i) begin
                    shreg_d = shift_next(shreg_q);
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_i) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick_i) begin
                    if (cnt_q == STOP_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level for the bit that begins on this edge
        case (state_d)
            START:   serial_d = UART_START_LVL;
            DATA:    serial_d = head_bit(shreg_d);
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = par_d;
`endif
            default: serial_d = UART_IDLE_LVL;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            serial_o <= UART_IDLE_LVL;
            busy_o   <= 1'b0;
            ready_o  <= 1'b1;
            done_o   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            serial_o <= serial_d;
            busy_o   <= (state_d != IDLE);
            ready_o  <= (state_d == IDLE);
            done_o   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: four configurations share one baud tick; a monitor checks every line bit.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [3:0] rst;
    logic [3:0] valid_v;
    logic [3:0] ready_w, serial_w, busy_w, done_w;
    logic       tick;
    logic [8:0] data_v [4];

    int checks = 0;
    int errors = 0;

    logic exp_bits [4][$];
    int   exp_len  [4][$];
    int   mode     [4];
    int   left     [4];
    bit   first    [4];
    bit   mon_en   [4];
    bit   tick_en;

    uart_tx_framer #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(0)) u_lsb (
        .Clk(Clk), .rst(rst[0]), .tick_i(tick), .valid_i(valid_v[0]), .data_i(data_v[0][7:0]),
        .ready_o(ready_w[0]), .serial_o(serial_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
    uart_tx_framer #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(0)) u_msb (
        .Clk(Clk), .rst(rst[1]), .tick_i(tick), .valid_i(valid_v[1]), .data_i(data_v[1][7:0]),
        .ready_o(ready_w[1]), .serial_o(serial_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
    uart_tx_framer #(.DATA_W(5), .STOP_BITS(2), .MSB_FIRST(0), .PARITY_ODD(0)) u_w5 (
        .Clk(Clk), .rst(rst[2]), .tick_i(tick), .valid_i(valid_v[2]), .data_i(data_v[2][4:0]),
        .ready_o(ready_w[2]), .serial_o(serial_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));
    uart_tx_framer #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(1)) u_odd (
        .Clk(Clk), .rst(rst[3]), .tick_i(tick), .valid_i(valid_v[3]), .data_i(data_v[3][7:0]),
        .ready_o(ready_w[3]), .serial_o(serial_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // bits: send order, first-sent bit at index n-1 (hand-written per vector)
    task automatic push_frame(input int i, input int n, input logic [8:0] bits, input int stops, input logic par);
        exp_bits[i].push_back(1'b0);
        for (int k = n - 1; k >= 0; k--) exp_bits[i].push_back(bits[k]);
        if (PAR_EN != 0) exp_bits[i].push_back(par);
        for (int s = 0; s < stops; s++) exp_bits[i].push_back(1'b1);
        exp_len[i].push_back(1 + n + PAR_EN + stops);
    endtask

    task automatic send(input int i, input logic [8:0] d, input bit hold);
        bit got;
        got = 1'b0;
        data_v[i]  = d;
        valid_v[i] = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge Clk);
            if (ready_w[i]) got = 1'b1;
        end
        if (!got) check("send_timeout", 32'(i), 32'hffff);
        @(posedge Clk); #1;
        if (!hold) valid_v[i] = 1'b0;
    endtask

    task automatic wait_drain();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            @(negedge Clk);
            idle = 1'b1;
            for (int i = 0; i < 4; i++)
                if (mode[i] != 0 || exp_bits[i].size() != 0 || valid_v[i]) idle = 1'b0;
        end
        if (!idle) check("drain_timeout", 32'd1, 32'd0);
        @(posedge Clk); #1;
    endtask

    // Baud strobe: one cycle high every 16 cycles
    initial begin
        tick = 1'b0;
        forever begin
            repeat (15) @(posedge Clk);
            #1 tick = tick_en;
            @(posedge Clk);
            #1 tick = 1'b0;
        end
    end

    // Monitor: tracks each framer from acceptance, compares the line on every tick, then done_o
    always @(negedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mon_en[i]) begin
                logic b;
                bool_blk: begin
                    bit done_slot;
                    done_slot = (mode[i] == 3);
                    if (mode[i] == 1 && first[i]) begin
                        check($sformatf("accept_ready_busy[%0d]", i), {30'd0, ready_w[i], busy_w[i]}, 32'd1);
                        first[i] = 1'b0;
                    end
                    case (mode[i])
                        1: if (tick) mode[i] = 2;
                        2: if (tick) begin
                            if (exp_bits[i].size() == 0) begin
                                check($sformatf("bit_queue_empty[%0d]", i), 32'd0, 32'd1);
                            end else begin
                                b = exp_bits[i].pop_front();
                                check($sformatf("serial[%0d] bit %0d", i, exp_len[i].size()), {31'd0, serial_w[i]}, {31'd0, b});
                            end
                            check($sformatf("busy_in_frame[%0d]", i), {31'd0, busy_w[i]}, 32'd1);
                            left[i]--;
                            if (left[i] == 0) mode[i] = 3;
                        end
                        3: begin
                            check($sformatf("done_ready[%0d]", i), {30'd0, done_w[i], ready_w[i]}, 32'd3);
                            mode[i] = 0;
                        end
                        default: ;
                    endcase
                    if (!done_slot && done_w[i])
                        check($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
                    if (mode[i] == 0 && valid_v[i] && ready_w[i]) begin
                        if (exp_len[i].size() == 0) begin
                            check($sformatf("unexpected_accept[%0d]", i), 32'd1, 32'd0);
                        end else begin
                            left[i]  = exp_len[i].pop_front();
                            mode[i]  = 1;
                            first[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        int n;
        rst     = 4'hf;
        valid_v = 4'h0;
        tick_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_v[i] = '0;
            mode[i]   = 0;
            left[i]   = 0;
            first[i]  = 1'b0;
            mon_en[i] = 1'b1;
        end
        repeat (3) @(posedge Clk);
        #1 rst = 4'h0;
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_serial[%0d]", i), {31'd0, serial_w[i]}, 32'd1);
            check($sformatf("reset_ready[%0d]", i), {31'd0, ready_w[i]}, 32'd1);
            check($sformatf("reset_busy[%0d]", i), {31'd0, busy_w[i]}, 32'd0);
            check($sformatf("reset_done[%0d]", i), {31'd0, done_w[i]}, 32'd0);
        end
        @(posedge Clk); #1;
        tick_en = 1'b1;

        // 0x31 LSB first: 1,0,0,0,1,1,0,0; even parity 1
        push_frame(0, 8, 9'b0_1000_1100, 1, 1'b1);
        send(0, 9'h031, 1'b0);
        // 0x31 MSB first: 0,0,1,1,0,0,0,1
        push_frame(1, 8, 9'b0_0011_0001, 1, 1'b1);
        send(1, 9'h031, 1'b0);
        // 0x1F, 5 bits, 2 stops
        push_frame(2, 5, 9'b0_0001_1111, 2, 1'b1);
        send(2, 9'h01f, 1'b0);
        // 0xA5 LSB first: 1,0,1,0,0,1,0,1; odd parity 1
        push_frame(3, 8, 9'b0_1010_0101, 1, 1'b1);
        send(3, 9'h0a5, 1'b0);
        wait_drain();

        // Back-to-back: valid held, data changes mid-frame ignored
        push_frame(0, 8, 9'b0_1010_1010, 1, 1'b0);
        push_frame(0, 8, 9'b0_0101_0101, 1, 1'b0);
        send(0, 9'h055, 1'b1);
        data_v[0] = 9'h077;
        repeat (60) @(posedge Clk);
        #1 data_v[0] = 9'h0aa;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge Clk);
            if (ready_w[0]) seen = 1'b1;
        end
        check("b2b_second_accept_in_done_cycle", {31'd0, done_w[0]}, 32'd1);
        @(posedge Clk); #1;
        data_v[0] = 9'h0f0;
        repeat (60) @(posedge Clk);
        #1 valid_v[0] = 1'b0;
        wait_drain();

        // Reset during data bit 3 aborts the frame
        mon_en[0] = 1'b0;
        send(0, 9'h031, 1'b0);
        n = 0;
        for (int c = 0; c < 400 && n < 5; c++) begin
            @(negedge Clk);
            if (tick) n++;
        end
        check("abort_tick_count", 32'(n), 32'd5);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("abort_bit3_level", {30'd0, serial_w[0], busy_w[0]}, 32'd1);
        @(posedge Clk); #1 rst[0] = 1'b1;
        @(posedge Clk); #1 rst[0] = 1'b0;
        @(negedge Clk);
        check("abort_serial_busy_ready", {29'd0, serial_w[0], busy_w[0], ready_w[0]}, 32'd5);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            if (done_w[0] || busy_w[0]) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        @(posedge Clk); #1;
        mode[0]   = 0;
        mon_en[0] = 1'b1;

        // Fresh frame after abort: 0x31 again
        push_frame(0, 8, 9'b0_1000_1100, 1, 1'b1);
        send(0, 9'h031, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
